// File: rtl/arg_sequencer_if.sv
// Handshake bundle between the argument sequencer and the argument subparser.
// The sequencer (master) starts a parse and names the slot being parsed;
// the subparser (slave) reports readiness, completion and the parsed values.
interface arg_sequencer_if #(
    parameter int NUM_BITS         = 8,
    parameter int PRECISE_NUM_BITS = 16
);
    typedef logic [7:0] char_t;

    logic                        sub_trigger;
    char_t                       arg_title;
    logic                        sub_rdy;
    logic                        sub_done;
    logic                        sub_success;
    logic                        sub_arg_too_big;
    logic                        sub_is_newline;
    logic [NUM_BITS-1:0]         sub_num;
    logic [PRECISE_NUM_BITS-1:0] sub_precise_num;

    modport master (
        output sub_trigger, arg_title,
        input  sub_rdy, sub_done, sub_success, sub_arg_too_big, sub_is_newline,
               sub_num, sub_precise_num
    );

    modport slave (
        input  sub_trigger, arg_title,
        output sub_rdy, sub_done, sub_success, sub_arg_too_big, sub_is_newline,
               sub_num, sub_precise_num
    );
endinterface

// File: rtl/arg_sequencer.sv
// Walks the argument slots requested for one Gcode line (X, Y, I, J, lowest
// slot first), triggers the subparser once per slot, stores the parsed values
// and accumulates sticky error/line-end status. Everything advances only on
// clk_en cycles; the synchronous reset wins over clk_en.
module arg_sequencer #(
    parameter int NUM_BITS         = 8,
    parameter int PRECISE_NUM_BITS = 16,
    parameter int MAX_ARGS         = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clk_en,
    input  logic                             start,
    input  logic [MAX_ARGS-1:0]              arg_mask,
    output logic                             rdy,
    output logic                             done,
    arg_sequencer_if.master                  sub,
    output logic [MAX_ARGS*NUM_BITS-1:0]     nums,
    output logic [MAX_ARGS*PRECISE_NUM_BITS-1:0] precise_nums,
    output logic [MAX_ARGS-1:0]              found,
    output logic                             err_missing,
    output logic                             err_too_big,
    output logic                             line_end
);

    localparam int SLOT_W = (MAX_ARGS > 1) ? $clog2(MAX_ARGS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_TRIGGER,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                              state_q, state_d;
    logic [MAX_ARGS-1:0]                 pending_q, pending_d;
    logic [MAX_ARGS*NUM_BITS-1:0]        nums_q, nums_d;
    logic [MAX_ARGS*PRECISE_NUM_BITS-1:0] precise_q, precise_d;
    logic [MAX_ARGS-1:0]                 found_q, found_d;
    logic                                err_missing_q, err_missing_d;
    logic                                err_too_big_q, err_too_big_d;
    logic                                line_end_q, line_end_d;
    logic                                trigger_c;
    logic [SLOT_W-1:0]                   cur_slot;

    // ASCII title of a slot; slots beyond J have no letter and show '?'.
    function automatic logic [7:0] slot_title(input logic [SLOT_W-1:0] slot);
        case (int'(slot))
            0:       slot_title = 8'h58;  // X
            1:       slot_title = 8'h59;  // Y
            2:       slot_title = 8'h49;  // I
            3:       slot_title = 8'h4A;  // J
            default: slot_title = 8'h3F;  // ?
        endcase
    endfunction

    // Current slot is the lowest still-pending bit; it cannot move between
    // SELECT and the sub_done that clears it, so the title stays stable.
    always_comb begin
        cur_slot = '0;
        for (int k = MAX_ARGS - 1; k >= 0; k--) begin
            if (pending_q[k]) cur_slot = SLOT_W'(k);
        end
    end

    // Next-state and datapath updates of the sequencing FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        pending_d     = pending_q;
        nums_d        = nums_q;
        precise_d     = precise_q;
        found_d       = found_q;
        err_missing_d = err_missing_q;
        err_too_big_d = err_too_big_q;
        line_end_d    = line_end_q;
        trigger_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pending_d     = arg_mask;
                    nums_d        = '0;
                    precise_d     = '0;
                    found_d       = '0;
                    err_missing_d = 1'b0;
                    err_too_big_d = 1'b0;
                    line_end_d    = 1'b0;
                    state_d       = S_SELECT;
                end
            end

            S_SELECT: begin
                if (line_end_q) begin
                    // The line ended early: whatever is still pending is missing.
                    if (pending_q != '0) err_missing_d = 1'b1;
                    pending_d = '0;
                    state_d   = S_DONE;
                end else if (pending_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_TRIGGER;
                end
            end

            S_TRIGGER: begin
                if (sub.sub_rdy) begin
                    trigger_c = 1'b1;
                    state_d   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (sub.sub_done) begin
                    pending_d[cur_slot] = 1'b0;
                    if (sub.sub_success && !sub.sub_arg_too_big) begin
                        nums_d[int'(cur_slot)*NUM_BITS +: NUM_BITS] = sub.sub_num;
                        precise_d[int'(cur_slot)*PRECISE_NUM_BITS +: PRECISE_NUM_BITS] =
                            sub.sub_precise_num;
                        found_d[cur_slot] = 1'b1;
                    end
                    if (sub.sub_arg_too_big) err_too_big_d = 1'b1;
                    if (!sub.sub_success)    err_missing_d = 1'b1;
                    if (sub.sub_is_newline)  line_end_d    = 1'b1;
                    state_d = S_SELECT;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers: reset first, otherwise advance only on clk_en.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            // NOTE: result registers are reset too, so after power-up the outputs read "nothing parsed".
            state_q       <= S_IDLE;
            pending_q     <= '0;
            nums_q        <= '0;
            precise_q     <= '0;
            found_q       <= '0;
            err_missing_q <= 1'b0;
            err_too_big_q <= 1'b0;
            line_end_q    <= 1'b0;
        end else if (clk_en) begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            nums_q        <= nums_d;
            precise_q     <= precise_d;
            found_q       <= found_d;
            err_missing_q <= err_missing_d;
            err_too_big_q <= err_too_big_d;
            line_end_q    <= line_end_d;
        end
    end

    // The trigger is qualified by clk_en so it is seen exactly when the FSM leaves TRIGGER.
    assign sub.sub_trigger = trigger_c & clk_en;
    assign sub.arg_title   = slot_title(cur_slot);

    assign rdy          = (state_q == S_IDLE);
    assign done         = (state_q == S_DONE);
    assign nums         = nums_q;
    assign precise_nums = precise_q;
    assign found        = found_q;
    assign err_missing  = err_missing_q;
    assign err_too_big  = err_too_big_q;
    assign line_end     = line_end_q;

endmodule

// File: tb/tb_arg_sequencer.sv
// Directed bench for arg_sequencer: a hand-driven subparser answers each
// trigger, and every observation is compared against hand-computed values.
module tb_arg_sequencer;

    localparam int NB  = 8;
    localparam int PNB = 16;
    localparam int MA  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              clk_en;
    logic              start;
    logic [MA-1:0]     arg_mask;
    logic              rdy;
    logic              done;
    logic [MA*NB-1:0]  nums;
    logic [MA*PNB-1:0] precise_nums;
    logic [MA-1:0]     found;
    logic              err_missing;
    logic              err_too_big;
    logic              line_end;

    int n_checks  = 0;
    int n_errors  = 0;
    int trig_cnt  = 0;
    int done_cnt  = 0;
    int base_trig;
    int base_done;

    arg_sequencer_if #(.NUM_BITS(NB), .PRECISE_NUM_BITS(PNB)) sub_if ();

    arg_sequencer #(.NUM_BITS(NB), .PRECISE_NUM_BITS(PNB), .MAX_ARGS(MA)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_en       (clk_en),
        .start        (start),
        .arg_mask     (arg_mask),
        .rdy          (rdy),
        .done         (done),
        .sub          (sub_if),
        .nums         (nums),
        .precise_nums (precise_nums),
        .found        (found),
        .err_missing  (err_missing),
        .err_too_big  (err_too_big),
        .line_end     (line_end)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle; done counts only on cycles the DUT can advance.
    always @(negedge clk) begin
        if (sub_if.sub_trigger === 1'b1) trig_cnt++;
        if (done === 1'b1 && clk_en === 1'b1) done_cnt++;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a trigger, check the title, then answer one parse.
    task automatic serve(input string tag, input logic [7:0] title,
                         input logic [NB-1:0] num, input logic [PNB-1:0] pnum,
                         input logic succ, input logic big, input logic nl);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (sub_if.sub_trigger === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check({tag, " trigger seen"}, 64'(seen), 64'd1);
        check({tag, " title"}, 64'(sub_if.arg_title), 64'(title));
        step();
        sub_if.sub_done        = 1'b1;
        sub_if.sub_success     = succ;
        sub_if.sub_arg_too_big = big;
        sub_if.sub_is_newline  = nl;
        sub_if.sub_num         = num;
        sub_if.sub_precise_num = pnum;
        step();
        sub_if.sub_done        = 1'b0;
        sub_if.sub_success     = 1'b0;
        sub_if.sub_arg_too_big = 1'b0;
        sub_if.sub_is_newline  = 1'b0;
    endtask

    // Wait (bounded) until done is high; leaves the bench inside the DONE cycle.
    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check({tag, " done seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        reset                  = 1'b1;
        clk_en                 = 1'b1;
        start                  = 1'b0;
        arg_mask               = '0;
        sub_if.sub_rdy         = 1'b1;
        sub_if.sub_done        = 1'b0;
        sub_if.sub_success     = 1'b0;
        sub_if.sub_arg_too_big = 1'b0;
        sub_if.sub_is_newline  = 1'b0;
        sub_if.sub_num         = '0;
        sub_if.sub_precise_num = '0;

        // Reset state.
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst rdy", 64'(rdy), 64'd1);
        check("rst done", 64'(done), 64'd0);
        check("rst trigger", 64'(sub_if.sub_trigger), 64'd0);
        check("rst found", 64'(found), 64'd0);
        check("rst nums", 64'(nums), 64'd0);
        check("rst precise", precise_nums, 64'd0);
        check("rst errs", 64'({err_missing, err_too_big, line_end}), 64'd0);

        // Empty mask: done two clk_en cycles after start.
        base_done = done_cnt;
        start    = 1'b1;
        arg_mask = 4'b0000;
        step();
        start = 1'b0;
        #1;
        check("lat c1 rdy", 64'(rdy), 64'd0);
        check("lat c1 done", 64'(done), 64'd0);
        step();
        check("lat c2 done", 64'(done), 64'd1);
        step();
        check("lat c3 done", 64'(done), 64'd0);
        check("lat c3 rdy", 64'(rdy), 64'd1);
        check("lat done pulses", 64'(done_cnt - base_done), 64'd1);

        // X and Y both parse successfully.
        base_trig = trig_cnt;
        base_done = done_cnt;
        start    = 1'b1;
        arg_mask = 4'b0011;
        step();
        start    = 1'b0;
        arg_mask = '0;
        #1;
        check("xy select title", 64'(sub_if.arg_title), 64'h58);
        serve("xy X", 8'h58, 8'd12, 16'd1200, 1'b1, 1'b0, 1'b0);
        serve("xy Y", 8'h59, 8'hFB, 16'hFE0C, 1'b1, 1'b0, 1'b0);
        wait_done("xy");
        step();
        check("xy found", 64'(found), 64'h3);
        check("xy nums", 64'(nums), 64'h0000_FB0C);
        check("xy precise", precise_nums, 64'h0000_0000_FE0C_04B0);
        check("xy errs", 64'({err_missing, err_too_big, line_end}), 64'd0);
        check("xy triggers", 64'(trig_cnt - base_trig), 64'd2);
        check("xy done pulses", 64'(done_cnt - base_done), 64'd1);

        // All four requested, but the line ends after X.
        base_trig = trig_cnt;
        start    = 1'b1;
        arg_mask = 4'b1111;
        step();
        start = 1'b0;
        #1;
        check("nl cleared nums", 64'(nums), 64'd0);
        check("nl cleared found", 64'(found), 64'd0);
        serve("nl X", 8'h58, 8'd7, 16'd700, 1'b1, 1'b0, 1'b1);
        wait_done("nl");
        step();
        check("nl found", 64'(found), 64'h1);
        check("nl line_end", 64'(line_end), 64'd1);
        check("nl err_missing", 64'(err_missing), 64'd1);
        check("nl err_too_big", 64'(err_too_big), 64'd0);
        check("nl triggers", 64'(trig_cnt - base_trig), 64'd1);
        check("nl nums", 64'(nums), 64'h7);
        check("nl precise", precise_nums, 64'd700);

        // sub_done while idle must not touch results.
        sub_if.sub_done    = 1'b1;
        sub_if.sub_success = 1'b1;
        sub_if.sub_num     = 8'h99;
        step();
        sub_if.sub_done    = 1'b0;
        sub_if.sub_success = 1'b0;
        #1;
        check("idle sub_done found", 64'(found), 64'h1);
        check("idle sub_done nums", 64'(nums), 64'h7);

        // Slot I reports a too-big argument.
        start    = 1'b1;
        arg_mask = 4'b0100;
        step();
        start = 1'b0;
        serve("big I", 8'h49, 8'h55, 16'h1234, 1'b1, 1'b1, 1'b0);
        wait_done("big");
        step();
        check("big err_too_big", 64'(err_too_big), 64'd1);
        check("big found", 64'(found), 64'd0);
        check("big nums", 64'(nums), 64'd0);
        check("big precise", precise_nums, 64'd0);
        check("big err_missing", 64'(err_missing), 64'd0);
        check("big line_end", 64'(line_end), 64'd0);

        // Slot J with a slow subparser and clk_en toggling.
        base_trig = trig_cnt;
        base_done = done_cnt;
        sub_if.sub_rdy = 1'b0;
        start    = 1'b1;
        arg_mask = 4'b1000;
        step();
        start = 1'b0;
        step();
        #1;
        check("slow title", 64'(sub_if.arg_title), 64'h4A);
        for (int i = 0; i < 5; i++) begin
            clk_en = ((i % 2) != 0);
            #1;
            check("slow no trigger", 64'(sub_if.sub_trigger), 64'd0);
            check("slow busy", 64'(rdy), 64'd0);
            step();
        end
        clk_en         = 1'b0;
        sub_if.sub_rdy = 1'b1;
        #1;
        check("slow gated trigger", 64'(sub_if.sub_trigger), 64'd0);
        step();
        clk_en   = 1'b1;
        start    = 1'b1;
        arg_mask = 4'b0001;
        #1;
        check("slow trigger", 64'(sub_if.sub_trigger), 64'd1);
        step();
        start    = 1'b0;
        arg_mask = '0;
        #1;
        check("slow trigger ends", 64'(sub_if.sub_trigger), 64'd0);
        clk_en                 = 1'b0;
        sub_if.sub_done        = 1'b1;
        sub_if.sub_success     = 1'b1;
        sub_if.sub_num         = 8'hA5;
        sub_if.sub_precise_num = 16'hBEEF;
        step();
        check("slow frozen found", 64'(found), 64'd0);
        clk_en = 1'b1;
        step();
        sub_if.sub_done    = 1'b0;
        sub_if.sub_success = 1'b0;
        #1;
        check("slow found", 64'(found), 64'h8);
        check("slow nums", 64'(nums), 64'hA500_0000);
        check("slow precise", precise_nums, 64'hBEEF_0000_0000_0000);
        clk_en = 1'b0;
        step();
        check("slow frozen select", 64'(done), 64'd0);
        clk_en = 1'b1;
        step();
        check("slow done", 64'(done), 64'd1);
        clk_en = 1'b0;
        step();
        check("slow done held", 64'(done), 64'd1);
        check("slow rdy held low", 64'(rdy), 64'd0);
        clk_en = 1'b1;
        step();
        check("slow back idle", 64'(rdy), 64'd1);
        check("slow triggers", 64'(trig_cnt - base_trig), 64'd1);
        check("slow done pulses", 64'(done_cnt - base_done), 64'd1);

        // Reset while waiting on the subparser, with clk_en low.
        base_done = done_cnt;
        start    = 1'b1;
        arg_mask = 4'b0001;
        step();
        start    = 1'b0;
        arg_mask = '0;
        step();
        step();
        check("abort busy", 64'(rdy), 64'd0);
        reset  = 1'b1;
        clk_en = 1'b0;
        step();
        reset = 1'b0;
        check("abort rdy", 64'(rdy), 64'd1);
        check("abort done", 64'(done), 64'd0);
        check("abort found", 64'(found), 64'd0);
        check("abort nums", 64'(nums), 64'd0);
        check("abort precise", precise_nums, 64'd0);
        check("abort errs", 64'({err_missing, err_too_big, line_end}), 64'd0);
        clk_en = 1'b1;
        step();
        step();
        check("abort no done", 64'(done_cnt - base_done), 64'd0);
        start    = 1'b1;
        arg_mask = 4'b0000;
        step();
        start = 1'b0;
        #1;
        check("abort lat c1", 64'(done), 64'd0);
        step();
        check("abort lat c2", 64'(done), 64'd1);
        step();
        check("abort lat idle", 64'(rdy), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
